// File: rtl/lcd_line_fetch_pkg.sv
// Shared types, default geometry and fetch FSM encodings for the LCD line fetcher.
package lcd_line_fetch_pkg;

  localparam int H_DISP_DEF    = 800;
  localparam int V_DISP_DEF    = 480;
  localparam int BURST_LEN_DEF = 32;
  localparam int ADDR_W_DEF    = 21;
  localparam int RGB_W         = 24;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_FULL = 2'd3;

  function automatic logic is_busy(input logic [1:0] st);
    return (st == ST_REQ) || (st == ST_DATA);
  endfunction

endpackage

// File: rtl/lcd_line_fetch_if.sv
// Burst read port to external memory: req/addr held until ack, then BURST_LEN data beats.
interface lcd_line_fetch_if #(
  parameter int ADDR_W = 21
);
  import lcd_line_fetch_pkg::*;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  rgb_t              rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_valid,
    output rd_data
  );

endinterface

// File: rtl/lcd_line_fetch_line_buf.sv
// Ping-pong line store: simple dual-port RAM addressed {bank, x}, one write port, registered read.
module lcd_line_fetch_line_buf #(
  parameter int DW = 24,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/lcd_line_fetch.sv
// Prefetches the next display line by bursts into a ping-pong buffer; pixel out 1 clk after lcd_xpos.
// Optional LCD_FETCH_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module lcd_line_fetch
  import lcd_line_fetch_pkg::*;
#(
  parameter int          H_DISP    = H_DISP_DEF,
  parameter int          V_DISP    = V_DISP_DEF,
  parameter int          BURST_LEN = BURST_LEN_DEF,
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter int unsigned FB_BASE   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             line_start,
  input  logic [11:0]      lcd_xpos,
  output rgb_t             lcd_data,
  lcd_line_fetch_if.master mem,
  output logic             busy,
  output logic             underrun
`ifdef LCD_FETCH_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_cnt
`endif
);

  localparam int XW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int LW = $clog2(V_DISP + 1);

  localparam logic [XW:0]       X_LAST     = (XW+1)'(H_DISP - 1);
  localparam logic [XW:0]       X_ONE      = (XW+1)'(1);
  localparam logic [BW-1:0]     BEAT_LAST  = BW'(BURST_LEN - 1);
  localparam logic [BW-1:0]     BEAT_ONE   = BW'(1);
  localparam logic [LW-1:0]     LINE_LAST  = LW'(V_DISP - 1);
  localparam logic [LW-1:0]     LINE_ONE   = LW'(1);
  localparam logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BURST_LEN);
  localparam logic [11:0]       X_END      = 12'(H_DISP);

  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_addr;
  logic [XW:0]       wr_x;
  logic [BW-1:0]     beat_cnt;
  logic [LW-1:0]     lines_fetched;
  logic              fill_bank;
  logic              disp_bank;
  logic              disp_ok;
  logic              restart_pend;
  logic              frame_seen;
  logic              rd_ok_q;
  rgb_t              buf_q;

  logic in_fetch;
  logic wr_en;
  logic underrun_evt;
  logic swap;

  assign in_fetch    = is_busy(state);
  assign busy        = in_fetch;
  assign mem.rd_req  = (state == ST_REQ);
  assign mem.rd_addr = rd_addr;
  assign wr_en       = (state == ST_DATA) && mem.rd_valid;

  // A line_start that finds the next line still incomplete blanks that line instead of swapping.
  assign underrun_evt = line_start && !frame_start &&
                        (in_fetch || ((state == ST_IDLE) && frame_seen));
  assign swap         = line_start && !frame_start && (state == ST_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      rd_addr       <= '0;
      wr_x          <= '0;
      beat_cnt      <= '0;
      lines_fetched <= '0;
      fill_bank     <= 1'b0;
      disp_bank     <= 1'b1;
      disp_ok       <= 1'b0;
      underrun      <= 1'b0;
      restart_pend  <= 1'b0;
      frame_seen    <= 1'b0;
    end else begin
      if (frame_start) begin
        underrun      <= 1'b0;
        lines_fetched <= '0;
        frame_seen    <= 1'b1;
        // An open burst must still see its ack and all its beats; restart once it drains.
        if (in_fetch) begin
          restart_pend <= 1'b1;
        end else begin
          rd_addr   <= BASE_ADDR;
          wr_x      <= '0;
          fill_bank <= 1'b0;
          state     <= ST_REQ;
        end
      end

      if (underrun_evt) begin
        underrun <= 1'b1;
        disp_ok  <= 1'b0;
      end

      unique case (state)
        ST_REQ: begin
          if (mem.rd_ack) begin
            beat_cnt <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wr_en) begin
            wr_x     <= wr_x + X_ONE;
            beat_cnt <= beat_cnt + BEAT_ONE;
            if (beat_cnt == BEAT_LAST) begin
              if (restart_pend || frame_start) begin
                rd_addr      <= BASE_ADDR;
                wr_x         <= '0;
                fill_bank    <= 1'b0;
                restart_pend <= 1'b0;
                state        <= ST_REQ;
              end else begin
                rd_addr <= rd_addr + ADDR_STEP;
                state   <= (wr_x == X_LAST) ? ST_FULL : ST_REQ;
              end
            end
          end
        end
        ST_FULL: begin
          if (swap) begin
            disp_bank     <= fill_bank;
            fill_bank     <= ~fill_bank;
            disp_ok       <= 1'b1;
            lines_fetched <= lines_fetched + LINE_ONE;
            wr_x          <= '0;
            state         <= (lines_fetched == LINE_LAST) ? ST_IDLE : ST_REQ;
          end
        end
        default: ;
      endcase
    end
  end

  lcd_line_fetch_line_buf #(
    .DW (RGB_W),
    .AW (XW + 1)
  ) u_line_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({fill_bank, wr_x[XW-1:0]}),
    .wdata (mem.rd_data),
    .raddr ({disp_bank, lcd_xpos[XW-1:0]}),
    .rdata (buf_q)
  );

  // The gate travels with the RAM read so blanking and out-of-range x align with the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ok_q <= 1'b0;
    end else begin
      rd_ok_q <= disp_ok && (lcd_xpos < X_END);
    end
  end

  assign lcd_data = rd_ok_q ? buf_q : '0;

`ifdef LCD_FETCH_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (underrun_evt && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`else
  // Without the counter only the sticky underrun flag reports events.
`endif

endmodule

// File: tb/tb_lcd_line_fetch.sv
// Directed bench for lcd_line_fetch: small geometry, latency-modelled memory, hand-computed pixels.
module tb_lcd_line_fetch;
  import lcd_line_fetch_pkg::*;

  localparam int          H    = 64;
  localparam int          V    = 4;
  localparam int          B    = 16;
  localparam int          AW   = 21;
  localparam int unsigned BASE = 'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic [11:0] lcd_xpos = '0;
  rgb_t        lcd_data;
  logic        busy;
  logic        underrun;
`ifdef LCD_FETCH_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  lcd_line_fetch_if #(.ADDR_W(AW)) mem_if ();

  lcd_line_fetch #(
    .H_DISP    (H),
    .V_DISP    (V),
    .BURST_LEN (B),
    .ADDR_W    (AW),
    .FB_BASE   (BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .lcd_xpos     (lcd_xpos),
    .lcd_data     (lcd_data),
    .mem          (mem_if),
    .busy         (busy),
    .underrun     (underrun)
`ifdef LCD_FETCH_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: ack 2 clk after req is seen, first beat 3 clk after ack, data = pixel address.
  int              m_state = 0;
  int              m_cnt   = 0;
  int              m_delay = 2;
  int              m_beat  = 0;
  int              viol    = 0;
  logic            stall_next = 1'b0;
  logic [AW-1:0]   m_addr = '0;
  logic [AW-1:0]   req_log [$];

  initial begin
    mem_if.rd_ack   = 1'b0;
    mem_if.rd_valid = 1'b0;
    mem_if.rd_data  = '0;
    forever begin
      @(negedge clk);
      mem_if.rd_ack   = 1'b0;
      mem_if.rd_valid = 1'b0;
      if (rst) begin
        m_state = 0;
        continue;
      end
      case (m_state)
        0: if (mem_if.rd_req) begin
             m_addr = mem_if.rd_addr;
             req_log.push_back(m_addr);
             m_delay = stall_next ? 200 : 2;
             stall_next = 1'b0;
             m_cnt = 1;
             m_state = 1;
           end
        1: begin
             if (!mem_if.rd_req || (mem_if.rd_addr != m_addr)) viol++;
             if (m_cnt >= m_delay) begin
               mem_if.rd_ack = 1'b1;
               m_cnt = 0;
               m_state = 2;
             end else begin
               m_cnt++;
             end
           end
        2: begin
             m_cnt++;
             if (m_cnt == 3) begin
               m_beat = 0;
               m_state = 3;
             end
           end
        default: ;
      endcase
      if (m_state == 3) begin
        mem_if.rd_valid = 1'b1;
        mem_if.rd_data  = 24'(m_addr + AW'(m_beat));
        m_beat++;
        if (m_beat == B) m_state = 0;
      end
    end
  end

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pulse_ls();
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 3000), 1);
  endtask

  task automatic wait_req(input int n, input string tag);
    int k = 0;
    while (req_log.size() <= n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(req_log.size() > n), 1);
  endtask

  task automatic read_px(input logic [11:0] x, input logic [31:0] exp, input string tag);
    lcd_xpos = x;
    @(negedge clk);
    chk(tag, lcd_data, exp);
  endtask

  initial begin
    int n;
    int k;
    repeat (3) @(negedge clk);
    chk("rst_rd_req",   mem_if.rd_req, 0);
    chk("rst_busy",     busy, 0);
    chk("rst_lcd_data", lcd_data, 0);
    chk("rst_underrun", underrun, 0);
`ifdef LCD_FETCH_UNDERRUN_CNT_EN
    chk("rst_ucnt", underrun_cnt, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Frame start fetches line 0 in four bursts, then parks in FULL.
    pulse_fs();
    chk("t1_busy", busy, 1);
    wait_idle("t1_fill_timeout");
    chk("t1_nreq", req_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_addr%0d", i), 32'(req_log[i]), BASE + 32'(16 * i));
    chk("t1_rd_req_low", mem_if.rd_req, 0);
    chk("t1_black_before_swap", 32'(lcd_data), 0);
    read_px(12'd0, 0, "t1_px0_no_disp");

    // First line displayed, one clk after each xpos.
    pulse_ls();
    for (int x = 0; x < H; x++)
      read_px(12'(x), BASE + 32'(x), $sformatf("t2_px%0d", x));
    read_px(12'd64, 0, "t2_xpos_eq_hdisp");
    read_px(12'hFFF, 0, "t2_xpos_max");
    wait_req(4, "t2_next_timeout");
    chk("t2_next_addr", 32'(req_log[4]), 'h140);

    // Rest of the frame.
    wait_idle("t3_l1_timeout");
    pulse_ls();
    wait_idle("t3_l2_timeout");
    pulse_ls();
    wait_idle("t3_l3_timeout");
    pulse_ls();
    repeat (50) @(negedge clk);
    chk("t3_nreq", req_log.size(), 16);
    chk("t3_last_addr", 32'(req_log[15]), 'h1F0);
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_rd_req", mem_if.rd_req, 0);
    chk("t3_underrun", underrun, 0);
    read_px(12'd0, 'h1C0, "t3_line3_px0");
    read_px(12'd63, 'h1FF, "t3_line3_px63");

    // Stalled fetch: line_start while line 1 is still being fetched.
    pulse_fs();
    wait_idle("t4_l0_timeout");
    stall_next = 1'b1;
    pulse_ls();
    repeat (5) @(negedge clk);
    chk("t4_busy_stalled", busy, 1);
    pulse_ls();
    chk("t4_underrun_set", underrun, 1);
`ifdef LCD_FETCH_UNDERRUN_CNT_EN
    chk("t4_ucnt", underrun_cnt, 1);
`endif
    read_px(12'd5, 0, "t4_black_line");
    wait_idle("t4_l1_timeout");
    pulse_ls();
    chk("t4_underrun_sticky", underrun, 1);
    read_px(12'd5, 'h145, "t4_slipped_line1");

    // Frame start in the middle of a burst.
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!(m_state == 3 && m_beat == 5) && k < 3000);
    chk("t5_beat5_timeout", 32'(k < 3000), 1);
    @(negedge clk);
    n = req_log.size();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("t5_underrun_clr", underrun, 0);
    chk("t5_busy_draining", busy, 1);
    wait_req(n, "t5_restart_timeout");
    chk("t5_restart_addr", 32'(req_log[n]), BASE);
    wait_idle("t5_l0_timeout");
    chk("t5_nreq", req_log.size(), n + 4);
    pulse_ls();
    read_px(12'd0, 'h100, "t5_px0");
    read_px(12'd17, 'h111, "t5_px17");
    read_px(12'd63, 'h13F, "t5_px63");
`ifdef LCD_FETCH_UNDERRUN_CNT_EN
    chk("t5_ucnt_kept", underrun_cnt, 1);
`endif

    // Reset during REQ.
    k = 0;
    while (mem_if.rd_req !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("t6_req_timeout", 32'(k < 3000), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rd_req", mem_if.rd_req, 0);
    chk("t6_busy", busy, 0);
    chk("t6_lcd_data", lcd_data, 0);
    chk("t6_underrun", underrun, 0);
`ifdef LCD_FETCH_UNDERRUN_CNT_EN
    chk("t6_ucnt", underrun_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_idle_no_req", mem_if.rd_req, 0);
    n = req_log.size();
    pulse_fs();
    wait_idle("t6_l0_timeout");
    chk("t6_nreq", req_log.size(), n + 4);
    chk("t6_addr0", 32'(req_log[n]), BASE);
    pulse_ls();
    read_px(12'd10, 'h10A, "t6_px10");
    chk("proto_req_stable", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
